// File: rtl/registrador_pkg.sv
// Shared types and constants for the packing-register controller.
// T codes, FSM states, op flags and the shadow packing rule live here.
package registrador_pkg;

   localparam int unsigned LOAD_W   = 5;
   localparam int unsigned SHADOW_W = 6;

   localparam logic [1:0] T_RESET = 2'b00;
   localparam logic [1:0] T_LOAD  = 2'b01;
   localparam logic [1:0] T_HOLD  = 2'b10;

   typedef enum logic [2:0] {
      S_CLR0  = 3'd0,
      S_IDLE  = 3'd1,
      S_CLEAR = 3'd2,
      S_LOAD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef enum logic {
      OP_CLEAR = 1'b0,
      OP_LOAD  = 1'b1
   } op_t;

   // The register stores the MSB of the load word above an always-zero bit.
   function automatic logic [SHADOW_W-1:0] pack_shadow(input logic [LOAD_W-1:0] d);
      return {d[4], 1'b0, d[3:0]};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps upward.
module rr_arbiter #(
   parameter int unsigned N = 3,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   localparam int unsigned SUM_W = IDX_W + 1;

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [SUM_W-1:0] sum;

   // Rotate so bit 0 is the pointer position; the lowest set offset wins.
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[N-1:0];
      sum = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = {1'b0, ptr} + SUM_W'(i);
         end
      end
      if (sum >= SUM_W'(N)) begin
         sum = sum - SUM_W'(N);
      end
      any = |rot;
      idx = sum[IDX_W-1:0];
      gnt = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/registrador_ctrl.sv
// Sequences the packing register's in/T pins, arbitrates loads among requesters
// round-robin, services clear requests and tracks the register value in a shadow.
module registrador_ctrl
   import registrador_pkg::*;
#(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned DATA_W = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic                      clr_req,
   output logic [N_REQ-1:0]          grant,
   output logic                      clr_ack,
   output logic [DATA_W-1:0]         reg_in,
   output logic [1:0]                reg_t,
   output logic                      busy,
   output logic [SHADOW_W-1:0]       shadow
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t               state_q, state_d;
   op_t                  op_q, op_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [N_REQ-1:0]     grant_q, grant_d;
   logic                 clr_ack_q, clr_ack_d;
   logic [DATA_W-1:0]    reg_in_q, reg_in_d;
   logic [1:0]           reg_t_q, reg_t_d;
   logic                 busy_q, busy_d;
   logic [SHADOW_W-1:0]  shadow_q, shadow_d;

   logic [N_REQ-1:0]     arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;
   logic [DATA_W-1:0]    win_data;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Winner's data, selected by the one-hot grant.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next state and registered outputs, computed for the state being entered.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      data_d    = data_q;
      grant_d   = '0;
      clr_ack_d = 1'b0;
      reg_in_d  = reg_in_q;
      reg_t_d   = T_HOLD;
      shadow_d  = shadow_q;
      case (state_q)
         S_CLR0: begin
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               op_d    = OP_CLEAR;
               reg_t_d = T_RESET;
            end else if (arb_any) begin
               state_d  = S_LOAD;
               op_d     = OP_LOAD;
               win_d    = arb_idx;
               data_d   = win_data;
               reg_in_d = win_data;
               reg_t_d  = T_LOAD;
            end
         end
         S_CLEAR: begin
            state_d   = S_DONE;
            shadow_d  = '0;
            clr_ack_d = 1'b1;
         end
         S_LOAD: begin
            state_d  = S_DONE;
            shadow_d = pack_shadow(data_q);
            grant_d  = N_REQ'(1) << win_q;
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (op_q == OP_LOAD) begin
               ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = S_CLR0;
            reg_t_d = T_RESET;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_CLR0;
         op_q      <= OP_CLEAR;
         win_q     <= '0;
         ptr_q     <= '0;
         data_q    <= '0;
         grant_q   <= '0;
         clr_ack_q <= 1'b0;
         reg_in_q  <= '0;
         reg_t_q   <= T_RESET;
         busy_q    <= 1'b1;
         shadow_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         clr_ack_q <= clr_ack_d;
         reg_in_q  <= reg_in_d;
         reg_t_q   <= reg_t_d;
         busy_q    <= busy_d;
         shadow_q  <= shadow_d;
      end
   end

   assign grant   = grant_q;
   assign clr_ack = clr_ack_q;
   assign reg_in  = reg_in_q;
   assign reg_t   = reg_t_q;
   assign busy    = busy_q;
   assign shadow  = shadow_q;

endmodule
